// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_fetch_ctrl_pkg;

    localparam int          XLEN       = 64;
    localparam int          CTRLBUS_IF = 1;
    localparam logic [31:0] INST_NOP   = 32'h0000_0013;

    // One instruction-buffer entry as delivered to ID.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic            fault;
    } ibuf_entry_t;

    // Picks the 32-bit instruction out of a 64-bit bus beat using pc[2].
    function automatic logic [31:0] select_word(input logic [63:0] rdata, input logic hi);
        return hi ? rdata[63:32] : rdata[31:0];
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO with synchronous clear, occupancy count and full/empty flags.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; clear wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array; contents are only meaningful behind the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch stage: issues one bus read per PC, tracks outstanding reads,
// drops responses made stale by a flush and delivers {pc, inst, fault} in order to ID.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int MAX_OUTST  = 2,
    parameter int IBUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      stall_valid_i,
    input  logic [5:0]      flush_valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            read_req_i,
    output logic            pc_advance_o,
    output logic            if_req_valid_o,
    output logic [XLEN-1:0] if_req_addr_o,
    input  logic            addr_ok_i,
    input  logic [63:0]     if_rdata_i,
    input  logic            if_rdata_valid_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_addr_o,
    output logic [31:0]     inst_o,
    output logic            inst_fault_o
);

    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int IW = $clog2(IBUF_DEPTH + 1);

    logic [OW-1:0]   out_cnt;
    logic [OW-1:0]   discard_cnt;
    logic            stall_if, flush_if, misaligned, credit, issue_ok;
    logic            accept, mis_push, resp, resp_keep;
    logic            ibuf_push, ibuf_pop, ibuf_empty, ibuf_full;
    logic [IW-1:0]   ibuf_cnt;
    ibuf_entry_t     ibuf_in, ibuf_head;
    logic [XLEN-1:0] pend_pc;
    logic [OW-1:0]   pend_cnt;
    logic            pend_full, pend_empty;

    assign stall_if   = stall_valid_i[CTRLBUS_IF];
    assign flush_if   = flush_valid_i[CTRLBUS_IF];
    assign misaligned = (pc_i[1:0] != 2'b00);

    // Every outstanding read reserves an ibuf slot, so a response can always be stored.
    assign credit   = (int'(out_cnt) + int'(ibuf_cnt) - int'(ibuf_pop)) < IBUF_DEPTH;
    // rst gates the combinational outputs so they drop the moment reset asserts.
    assign issue_ok = rst & read_req_i & credit & ~stall_if & ~flush_if;

    assign if_req_valid_o = issue_ok & ~misaligned & (out_cnt < OW'(MAX_OUTST));
    assign if_req_addr_o  = if_req_valid_o ? {pc_i[XLEN-1:3], 3'b000} : '0;
    assign accept         = if_req_valid_o & addr_ok_i;
    // A misaligned PC waits for older reads to return so the fault entry stays in order.
    assign mis_push       = issue_ok & misaligned & (out_cnt == '0);
    assign pc_advance_o   = accept | mis_push;

    assign resp      = if_rdata_valid_i;
    assign resp_keep = resp & (discard_cnt == '0) & ~flush_if;
    assign ibuf_push = resp_keep | mis_push;
    assign ibuf_pop  = inst_valid_o & ~stall_if;

    assign ibuf_in = resp_keep ? '{pc: pend_pc, inst: select_word(if_rdata_i, pend_pc[2]), fault: 1'b0}
                               : '{pc: pc_i, inst: INST_NOP, fault: 1'b1};

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTST)) u_pend_q (
        .clk       (clk),
        .rst       (rst),
        .clr       (1'b0),
        .push      (accept),
        .push_data (pc_i),
        .pop       (resp),
        .head      (pend_pc),
        .count     (pend_cnt),
        .full      (pend_full),
        .empty     (pend_empty)
    );

    fetch_fifo #(.WIDTH($bits(ibuf_entry_t)), .DEPTH(IBUF_DEPTH)) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush_if),
        .push      (ibuf_push),
        .push_data (ibuf_in),
        .pop       (ibuf_pop),
        .head      (ibuf_head),
        .count     (ibuf_cnt),
        .full      (ibuf_full),
        .empty     (ibuf_empty)
    );

    assign inst_valid_o = ~ibuf_empty;
    assign inst_addr_o  = inst_valid_o ? ibuf_head.pc    : '0;
    assign inst_o       = inst_valid_o ? ibuf_head.inst  : '0;
    assign inst_fault_o = inst_valid_o & ibuf_head.fault;

    // Outstanding/discard bookkeeping; on flush every read still in flight after this cycle is stale.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_cnt     <= '0;
            discard_cnt <= '0;
        end else begin
            case ({accept, resp})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: ;
            endcase
            if (flush_if)
                discard_cnt <= out_cnt - OW'(resp);
            else if (resp && discard_cnt != '0)
                discard_cnt <= discard_cnt - 1'b1;
        end
    end

    a_out_max:   assert property (@(posedge clk) disable iff (!rst) out_cnt <= OW'(MAX_OUTST));
    a_ibuf_max:  assert property (@(posedge clk) disable iff (!rst) ibuf_cnt <= IW'(IBUF_DEPTH));
    a_discard:   assert property (@(posedge clk) disable iff (!rst) discard_cnt <= out_cnt);
    a_no_resp:   assert property (@(posedge clk) disable iff (!rst) if_rdata_valid_i |-> out_cnt != '0);
    a_pend_sync: assert property (@(posedge clk) disable iff (!rst) pend_cnt == out_cnt);
    a_pend_push: assert property (@(posedge clk) disable iff (!rst) accept |-> !pend_full);
    a_pend_pop:  assert property (@(posedge clk) disable iff (!rst) resp |-> !pend_empty);
    a_ibuf_ovf:  assert property (@(posedge clk) disable iff (!rst) (ibuf_push && !ibuf_pop && !flush_if) |-> !ibuf_full);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomised bench for if_fetch_ctrl with a queue-based reference model and an in-order scoreboard.
module tb_if_fetch_ctrl;
    import if_fetch_ctrl_pkg::*;

    localparam int DEPTH = 2;   // ibuf depth == max outstanding in this configuration

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall_valid_i = '0, flush_valid_i = '0;
    logic [63:0] pc_i = '0;
    logic        read_req_i = 1'b0, addr_ok_i = 1'b0, if_rdata_valid_i = 1'b0;
    logic [63:0] if_rdata_i = '0;
    logic        pc_advance_o, if_req_valid_o, inst_valid_o, inst_fault_o;
    logic [63:0] if_req_addr_o, inst_addr_o;
    logic [31:0] inst_o;

    if_fetch_ctrl dut (
        .clk(clk), .rst(rst), .stall_valid_i(stall_valid_i), .flush_valid_i(flush_valid_i),
        .pc_i(pc_i), .read_req_i(read_req_i), .pc_advance_o(pc_advance_o),
        .if_req_valid_o(if_req_valid_o), .if_req_addr_o(if_req_addr_o), .addr_ok_i(addr_ok_i),
        .if_rdata_i(if_rdata_i), .if_rdata_valid_i(if_rdata_valid_i), .inst_valid_o(inst_valid_o),
        .inst_addr_o(inst_addr_o), .inst_o(inst_o), .inst_fault_o(inst_fault_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; bit stale; } pend_t;
    typedef struct { logic [63:0] data; int due; } bus_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; logic fault; } ent_t;

    pend_t pend_q[$];   // reads the bus has accepted and not yet answered
    bus_t  bus_q[$];    // bench bus: data and return cycle per accepted read
    ent_t  exp_q[$];    // expected ibuf contents, oldest first
    bit    stg_clear, stg_push;
    ent_t  stg_item;

    int          n_cmp = 0, n_err = 0, cyc = 0;
    int          lat_min = 0, lat_max = 3;
    bit          fix_data = 0, last_resp = 0;
    logic [63:0] fixed_data = '0;
    logic [63:0] cur_pc = 64'h8000_0000;
    int          adv_seen = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void timeout(string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endfunction

    // One clock cycle: drive inputs, check request-side outputs, advance the model.
    task automatic step(input bit stall, input bit flush, input bit rreq, input bit aok);
        bit          resp, pop_now, credit, go, e_req, e_mis;
        pend_t       p;
        bus_t        b;
        logic [63:0] d;
        @(posedge clk);
        #1;
        cyc++;
        if (stg_clear) exp_q.delete();
        if (stg_push)  exp_q.push_back(stg_item);
        stg_clear = 0;
        stg_push  = 0;
        resp = (bus_q.size() != 0) && (bus_q[0].due <= cyc);
        last_resp = resp;
        stall_valid_i = 6'($urandom);
        stall_valid_i[CTRLBUS_IF] = stall;
        flush_valid_i = 6'($urandom);
        flush_valid_i[CTRLBUS_IF] = flush;
        pc_i = cur_pc;
        read_req_i = rreq;
        addr_ok_i = aok;
        if_rdata_valid_i = resp;
        if_rdata_i = resp ? bus_q[0].data : {$urandom, $urandom};
        #1;
        pop_now = (exp_q.size() != 0) && !stall;
        credit  = (pend_q.size() + exp_q.size() - (pop_now ? 1 : 0)) < DEPTH;
        go      = rreq && credit && !stall && !flush;
        e_req   = go && (cur_pc[1:0] == 2'b00) && (pend_q.size() < DEPTH);
        e_mis   = go && (cur_pc[1:0] != 2'b00) && (pend_q.size() == 0);
        check("req_valid", 64'(if_req_valid_o), 64'(e_req));
        check("pc_advance", 64'(pc_advance_o), 64'((e_req && aok) || e_mis));
        if (e_req) check("req_addr", if_req_addr_o, {cur_pc[63:3], 3'b000});
        adv_seen += pc_advance_o ? 1 : 0;
        if (resp) begin
            p = pend_q.pop_front();
            b = bus_q.pop_front();
            if (!p.stale && !flush) begin
                stg_push = 1;
                stg_item = '{pc: p.pc, inst: (p.pc[2] ? b.data[63:32] : b.data[31:0]), fault: 1'b0};
            end
        end
        if (flush) foreach (pend_q[i]) pend_q[i].stale = 1;
        stg_clear = flush;
        if (e_mis) begin
            stg_push = 1;
            stg_item = '{pc: cur_pc, inst: 32'h0000_0013, fault: 1'b1};
        end
        if (e_req && aok) begin
            d = fix_data ? fixed_data : {$urandom, $urandom};
            pend_q.push_back('{pc: cur_pc, stale: 1'b0});
            bus_q.push_back('{data: d, due: cyc + 1 + int'($urandom_range(lat_max, lat_min))});
        end
        if ((e_req && aok) || e_mis) cur_pc = cur_pc + 64'd4;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 40; i++) begin
            if (pend_q.size() == 0 && exp_q.size() == 0 && !stg_push) break;
            step(0, 0, 0, 1);
        end
        if (i == 40) timeout("drain");
    endtask

    // Scoreboard: the ibuf head must match the oldest expected entry every cycle it is shown.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            check("inst_valid", 64'(inst_valid_o), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check("inst_addr", inst_addr_o, exp_q[0].pc);
                check("inst_word", 64'(inst_o), 64'(exp_q[0].inst));
                check("inst_fault", 64'(inst_fault_o), 64'(exp_q[0].fault));
                if (!stall_valid_i[CTRLBUS_IF]) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int a0, vcnt, i;
        pc_i = 64'h8000_0000;
        read_req_i = 1'b1;
        addr_ok_i = 1'b1;
        #3;
        check("rst_req_valid", 64'(if_req_valid_o), 64'd0);
        check("rst_pc_advance", 64'(pc_advance_o), 64'd0);
        check("rst_req_addr", if_req_addr_o, 64'd0);
        check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
        check("rst_inst", 64'(inst_o), 64'd0);
        read_req_i = 1'b0;
        addr_ok_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;

        // Aligned fetch pair sharing one bus beat: low word then high word.
        fix_data = 1;
        fixed_data = 64'h00100093_00000013;
        lat_min = 0; lat_max = 0;
        cur_pc = 64'h8000_0000;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        drain();
        fix_data = 0;

        // Credit limit, then stall holds the filled ibuf stable until release.
        lat_min = 3; lat_max = 3;
        a0 = adv_seen;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        repeat (8) step(1, 0, 1, 1);
        check("stall_accepts", 64'(adv_seen - a0), 64'd2);
        repeat (10) step(0, 0, 1, 1);
        drain();

        // Two reads in flight killed by a flush; their responses must not reach ID.
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 1, 0, 1);
        cur_pc = 64'h8000_1000;
        vcnt = 0;
        for (i = 0; i < 6; i++) begin
            step(0, 0, 0, 1);
            vcnt += inst_valid_o ? 1 : 0;
        end
        check("flush_no_deliver", 64'(vcnt), 64'd0);
        step(0, 0, 1, 1);
        drain();

        // Misaligned PC becomes a fault entry without a bus request.
        cur_pc = 64'h8000_0002;
        step(0, 0, 1, 1);
        cur_pc = 64'h8000_0010;
        drain();

        // Bus back-pressure: request held steady, no advance.
        cur_pc = 64'h8000_0040;
        repeat (5) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        drain();

        // Random traffic with stalls, flushes, redirects and misaligned targets.
        lat_min = 0; lat_max = 3;
        for (i = 0; i < 1500; i++) begin
            bit s, f;
            s = ($urandom_range(4, 0) == 0);
            f = ($urandom_range(11, 0) == 0);
            step(s, f, $urandom_range(7, 0) != 0, $urandom_range(3, 0) != 0);
            if (f) cur_pc = 64'h8000_0000 + 64'({$urandom_range(255, 0), 2'b00})
                            + (($urandom_range(7, 0) == 0) ? 64'd2 : 64'd0);
        end
        drain();

        // Asynchronous reset landing in the middle of a response cycle.
        lat_min = 1; lat_max = 1;
        cur_pc = 64'h8000_0100;
        for (i = 0; i < 20 && !last_resp; i++) step(0, 0, 1, 1);
        if (!last_resp) timeout("resp_before_reset");
        #1 rst = 1'b0;
        #1;
        check("arst_req_valid", 64'(if_req_valid_o), 64'd0);
        check("arst_pc_advance", 64'(pc_advance_o), 64'd0);
        check("arst_req_addr", if_req_addr_o, 64'd0);
        check("arst_inst_valid", 64'(inst_valid_o), 64'd0);
        check("arst_inst_addr", inst_addr_o, 64'd0);
        check("arst_inst", 64'(inst_o), 64'd0);
        check("arst_fault", 64'(inst_fault_o), 64'd0);
        pend_q.delete();
        bus_q.delete();
        exp_q.delete();
        stg_clear = 0;
        stg_push = 0;
        if_rdata_valid_i = 1'b0;
        read_req_i = 1'b0;
        addr_ok_i = 1'b0;
        stall_valid_i = '0;
        flush_valid_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        cur_pc = 64'h8000_0000;
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
